riscv_nn_fetch_fifo_ring: RTL and testbench

RISCV_NN_FETCH_FIFO_RING -- requirements
Module: riscv_nn_fetch_fifo_ring

---
 rtl/riscv_nn_fetch_fifo_ring_if.sv | 26 ++
 rtl/riscv_nn_fetch_fifo_ring.sv | 131 +++++++++++++
 tb/tb_riscv_nn_fetch_fifo_ring.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_nn_fetch_fifo_ring_if.sv
// Handshake bundle for the instruction fetch FIFO: fetch-side input, realigned
// instruction output, flush request and occupancy.
interface riscv_nn_fetch_fifo_ring_if #(
    parameter int CNT_W = 3
);
    logic             clear_i;
    logic [31:0]      in_addr_i;
    logic [31:0]      in_rdata_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_rdata_o;
    logic [31:0]      out_addr_o;
    logic [CNT_W-1:0] out_count_o;

    modport slave (
        input  clear_i, in_addr_i, in_rdata_i, in_valid_i, out_ready_i,
        output in_ready_o, out_valid_o, out_rdata_o, out_addr_o, out_count_o
    );

    modport master (
        output clear_i, in_addr_i, in_rdata_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_rdata_o, out_addr_o, out_count_o
    );
endinterface

// File: rtl/riscv_nn_fetch_fifo_ring.sv
// Circular instruction-fetch FIFO that realigns 16/32-bit RISC-V instructions.
// Optional same-cycle bypass of an empty FIFO: define FETCH_FIFO_BYPASS_EN.
module riscv_nn_fetch_fifo_ring #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    riscv_nn_fetch_fifo_ring_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic             in_ready_q, in_ready_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // View of the stored stream at cur_addr; zero halves where no entry exists.
    logic [31:0] head;
    logic [15:0] next_lo;
    logic        has1, has2, unal, fifo_is32, fifo_valid;
    logic [31:0] fifo_rdata;

    assign head       = mem_q[rd_ptr_q];
    assign next_lo    = mem_q[ptr_inc(rd_ptr_q)][15:0];
    assign has1       = (count_q != '0);
    assign has2       = (count_q >= CNT_W'(2));
    assign unal       = cur_addr_q[1];
    assign fifo_is32  = unal ? (head[17:16] == 2'b11) : (head[1:0] == 2'b11);
    assign fifo_valid = (unal && fifo_is32) ? has2 : has1;
    assign fifo_rdata = !has1 ? 32'h0 :
                        unal  ? {(has2 ? next_lo : 16'h0), head[31:16]} : head;

`ifdef FETCH_FIFO_BYPASS_EN
    logic byp_sel, byp_is32;
    assign byp_sel  = (count_q == '0) && bus.in_valid_i && !bus.clear_i;
    assign byp_is32 = bus.in_addr_i[1] ? (bus.in_rdata_i[17:16] == 2'b11)
                                       : (bus.in_rdata_i[1:0] == 2'b11);
`endif

    logic        out_valid, out_is32, out_unal, fire, do_write, do_pop;
    logic [31:0] out_rdata, out_addr;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        out_valid = fifo_valid;
        out_rdata = fifo_rdata;
        out_addr  = cur_addr_q;
        out_is32  = fifo_is32;
        out_unal  = unal;
`ifdef FETCH_FIFO_BYPASS_EN
        if (byp_sel) begin
            out_valid = !(bus.in_addr_i[1] && byp_is32);
            out_rdata = bus.in_addr_i[1] ? {16'h0, bus.in_rdata_i[31:16]} : bus.in_rdata_i;
            out_addr  = bus.in_addr_i;
            out_is32  = byp_is32;
            out_unal  = bus.in_addr_i[1];
        end
`endif
        fire     = out_valid && bus.out_ready_i && !bus.clear_i;
        do_write = bus.in_valid_i && in_ready_q && !bus.clear_i;
        // An aligned compressed instruction leaves its upper half in the head entry.
        do_pop   = fire && (out_unal || out_is32);
`ifdef FETCH_FIFO_BYPASS_EN
        if (byp_sel) begin
            do_pop = 1'b0;
            if (fire && (out_unal || out_is32)) begin
                do_write = 1'b0;
            end
        end
`endif

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        cur_addr_d = cur_addr_q;
        if (bus.clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_write) - CNT_W'(do_pop);
            if (fire) begin
                cur_addr_d = out_addr + (out_is32 ? 32'd4 : 32'd2);
            end else if (do_write && (count_q == '0)) begin
                cur_addr_d = bus.in_addr_i;
            end
        end
        in_ready_d = (count_d <= CNT_W'(DEPTH - 2));
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cur_addr_q <= '0;
            in_ready_q <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            cur_addr_q <= cur_addr_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: entry storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= bus.in_rdata_i;
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid;
    assign bus.out_rdata_o = out_rdata;
    assign bus.out_addr_o  = out_addr;
    assign bus.out_count_o = count_q;

    a_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.in_valid_i && !bus.in_ready_o))
        else $error("in_valid_i asserted while in_ready_o is low");
endmodule

// File: tb/tb_riscv_nn_fetch_fifo_ring.sv
// Scoreboard bench: a halfword-stream model predicts the instruction sequence.
module tb_riscv_nn_fetch_fifo_ring;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    riscv_nn_fetch_fifo_ring_if #(.CNT_W(CNT_W)) bus ();
    riscv_nn_fetch_fifo_ring #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is32;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hw_q[$];
    logic [31:0] pc;
    bit          fresh = 1'b1;
    bit          rnd_ready = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: instructions are parsed from the halfword stream in address order.
    task automatic model_push(input logic [31:0] addr, input logic [31:0] word);
        logic [15:0] h0, h1;
        exp_t e;
        if (fresh) begin
            pc = addr;
            fresh = 1'b0;
            if (!addr[1]) hw_q.push_back(word[15:0]);
        end else begin
            hw_q.push_back(word[15:0]);
        end
        hw_q.push_back(word[31:16]);
        while (hw_q.size() > 0) begin
            h0 = hw_q[0];
            if (h0[1:0] != 2'b11) begin
                e.addr = pc; e.data = {16'h0, h0}; e.is32 = 1'b0;
                exp_q.push_back(e);
                pc = pc + 2;
                void'(hw_q.pop_front());
            end else if (hw_q.size() >= 2) begin
                h1 = hw_q[1];
                e.addr = pc; e.data = {h1, h0}; e.is32 = 1'b1;
                exp_q.push_back(e);
                pc = pc + 4;
                void'(hw_q.pop_front());
                void'(hw_q.pop_front());
            end else begin
                break;
            end
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        hw_q.delete();
        fresh = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic push_word(input logic [31:0] addr, input logic [31:0] word);
        int n = 0;
        while (!bus.in_ready_o && n < 50) begin
            step();
            n++;
        end
        if (!bus.in_ready_o) begin
            check("push_ready_timeout", {31'h0, bus.in_ready_o}, 32'h1);
        end else begin
            bus.in_valid_i = 1'b1;
            bus.in_addr_i  = addr;
            bus.in_rdata_i = word;
            model_push(addr, word);
            step();
            bus.in_valid_i = 1'b0;
        end
    endtask

    task automatic clear_fifo(input bit with_word, input logic [31:0] addr, input logic [31:0] word);
        bus.clear_i    = 1'b1;
        bus.in_valid_i = with_word;
        bus.in_addr_i  = addr;
        bus.in_rdata_i = word;
        model_flush();
        step();
        bus.clear_i    = 1'b0;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rnd_ready = 1'b0;
        bus.out_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else h[1:0] = 2'($urandom_range(0, 2));
        return h;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return {a[31:2], 2'b00} + 32'd4;
    endfunction

    // Monitor: compares every consumed instruction against the scoreboard.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!bus.clear_i && bus.out_valid_o && bus.out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual addr=0x%08h data=0x%08h required none",
                                 bus.out_addr_o, bus.out_rdata_o);
                    end else begin
                        e = exp_q.pop_front();
                        act = e.is32 ? bus.out_rdata_o : {16'h0, bus.out_rdata_o[15:0]};
                        check("out_addr", bus.out_addr_o, e.addr);
                        check("out_rdata", act, e.data);
                    end
                end
                check("in_ready_rule", {31'h0, bus.in_ready_o},
                      {31'h0, (int'(bus.out_count_o) <= DEPTH - 2)});
                check("count_bound", {31'h0, (int'(bus.out_count_o) <= DEPTH - 1)}, 32'h1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int nw;
        rst_n = 1'b0;
        bus.clear_i = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_addr_i = '0;
        bus.in_rdata_i = '0;
        bus.out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'h0, bus.out_valid_o}, 32'h0);
        check("rst_in_ready", {31'h0, bus.in_ready_o}, 32'h1);
        check("rst_count", {{(32-CNT_W){1'b0}}, bus.out_count_o}, 32'h0);
        check("rst_out_addr", bus.out_addr_o, 32'h0);
        check("rst_out_rdata", bus.out_rdata_o, 32'h0);
        rst_n = 1'b1;
        step();

        // Single aligned 32-bit instruction.
        bus.out_ready_i = 1'b1;
        push_word(32'h100, 32'h0000_0013);
`ifndef FETCH_FIFO_BYPASS_EN
        check("t032_valid", {31'h0, bus.out_valid_o}, 32'h1);
        check("t032_rdata", bus.out_rdata_o, 32'h0000_0013);
        check("t032_addr", bus.out_addr_o, 32'h100);
`endif
        step();
        check("t032_count", bus.out_count_o, 0);
        drain();

        // Two compressed instructions in one word.
        clear_fifo(1'b0, '0, '0);
        push_word(32'h200, 32'h0001_4501);
        drain();
        check("t033_count", bus.out_count_o, 0);

        // Unaligned 32-bit instruction split across two words.
        clear_fifo(1'b0, '0, '0);
        bus.out_ready_i = 1'b0;
        push_word(32'h302, 32'h00B3_1234);
        step();
        step();
        check("t034_wait_valid", {31'h0, bus.out_valid_o}, 32'h0);
        check("t034_wait_count", bus.out_count_o, 1);
        push_word(32'h304, 32'hABCD_0000);
        check("t034_valid", {31'h0, bus.out_valid_o}, 32'h1);
        check("t034_rdata", bus.out_rdata_o, 32'h0000_00B3);
        check("t034_addr", bus.out_addr_o, 32'h302);
        drain();

        // Fill to the reserved-slot limit, then stream to wrap the pointers.
        clear_fifo(1'b0, '0, '0);
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_word(32'h500 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20));
            check("t035_count", bus.out_count_o, i + 1);
            check("t035_ready", {31'h0, bus.in_ready_o}, (i + 1 <= DEPTH - 2) ? 32'h1 : 32'h0);
        end
        step();
        step();
        check("t035_saturate", bus.out_count_o, 3);
        bus.out_ready_i = 1'b1;
        a = 32'h50C;
        for (int i = 0; i < 10; i++) begin
            push_word(a, {rand_half(), 14'($urandom), 2'b11});
            a = next_addr(a);
        end
        drain();
        check("t035_end_count", bus.out_count_o, 0);

        // Clear with a simultaneous input word.
        clear_fifo(1'b0, '0, '0);
        bus.out_ready_i = 1'b0;
        push_word(32'h600, 32'h1111_0013);
        push_word(32'h604, 32'h2222_0013);
        check("t036_count2", bus.out_count_o, 2);
        clear_fifo(1'b1, 32'h608, 32'hDEAD_BEEF);
        check("t036_count0", bus.out_count_o, 0);
        check("t036_valid0", {31'h0, bus.out_valid_o}, 32'h0);
        push_word(32'h700, 32'h0000_0013);
        drain();

`ifdef FETCH_FIFO_BYPASS_EN
        // Same-cycle bypass of an empty FIFO.
        clear_fifo(1'b0, '0, '0);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_addr_i  = 32'h400;
        bus.in_rdata_i = 32'h0000_0013;
        model_push(32'h400, 32'h0000_0013);
        #1;
        check("t037_valid", {31'h0, bus.out_valid_o}, 32'h1);
        check("t037_rdata", bus.out_rdata_o, 32'h0000_0013);
        check("t037_addr", bus.out_addr_o, 32'h400);
        step();
        bus.in_valid_i = 1'b0;
        check("t037_count", bus.out_count_o, 0);
        drain();
`endif

        // Randomized runs with random consumer back-pressure.
        for (int r = 0; r < 40; r++) begin
            clear_fifo(1'b0, '0, '0);
            a = 32'h1000 + (32'($urandom_range(0, 255)) << 2) + (32'($urandom_range(0, 1)) << 1);
            nw = $urandom_range(1, 12);
            rnd_ready = 1'b1;
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                push_word(a, {rand_half(), rand_half()});
                a = next_addr(a);
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
